riscv_if: RTL
=============

# riscv_if

Instruction-fetch stage sitting directly upstream of `riscv_id`. It owns the fetch PC, issues word requests to instruction memory over a request/response handshake, and buffers returned words in a small in-order queue. It presents `{instruction, pc}` to decode with a valid/ready handshake. It handles redirects from execute by flushing the queue and discarding stale in-flight responses, and it traps misaligned redirect targets.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: response queue entries, which also bound outstanding requests. Legal range 2..8.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `mem_req`  out  1  fetch request valid.
- `mem_addr`  out  32  fetch word address; bits [1:0] always 0.
- `mem_ready`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
- `mem_rdata`  in  32  response instruction word.
- `redirect`  in  1  flush and restart fetch, driven from execute for branches and jumps.
- `redirect_pc`  in  32  new fetch target.
- `id_ready`  in  1  decode accepts the current output.
- `valid`  out  1  `instruction`, `pc` and `exception` are meaningful.
- `instruction`  out  32  fetched word, fed to `riscv_id.instruction`.
- `pc`  out  32  address of `instruction`, fed to `riscv_id.pc`.
- `exception`  out  1  instruction-address-misaligned trap marker.

## Operation
- Registers:
  - `fetch_pc`: next request address.
  - `resp_pc`: address of the next kept response.
  - `O`: outstanding accepted requests, range 0..DEPTH.
  - `D`: responses still to discard, always D ≤ O.
  - Queue: `count` entries, each holding `{word, pc}`.
  - FSM state.
- FSM states:
  - FETCH: normal operation.
  - TRAP: presenting the exception entry.
  - HALT: idle, waiting for a redirect.
- `pop = valid & id_ready`.
- Issue, in FETCH only: `mem_req = !redirect & (O + count - pop < DEPTH)`. This term is combinational from `id_ready` and `redirect`.
- `mem_addr = fetch_pc`.
- On accept (`mem_req & mem_ready`): `fetch_pc += 4` (wraps modulo 2^32) and `O += 1`.
- On response (`mem_rvalid`): `O -= 1`.
  - If D > 0: the response is dropped and `D -= 1`.
  - Otherwise: push `{mem_rdata, resp_pc}` and `resp_pc += 4`.
- Output: in FETCH, `valid = count != 0`. `instruction` and `pc` come from the queue head, and `exception = 0`.
- Redirect with `redirect_pc[1:0] == 0`, from any state:
  - The queue is cleared.
  - `fetch_pc = resp_pc = redirect_pc`.
  - `D` is set to the value `O` takes after this cycle's response.
  - A response arriving in the redirect cycle is dropped.
  - `mem_req` is 0 that cycle.
  - The next state is FETCH.
- Redirect with `redirect_pc[1:0] != 0`:
  - Same flush as above.
  - The next state is TRAP.
  - The misaligned target is latched into `pc`.
- TRAP:
  - Outputs are `valid = 1`, `exception = 1`, `instruction = 32'h0000_0013` (nop) and `pc` = the latched target.
  - No requests are issued.
  - In-flight responses keep being discarded.
  - On `pop`, the next state is HALT.
- HALT: `valid = 0` and `mem_req = 0` until the next redirect.
- A redirect takes priority over `pop`, a response and an accept in the same cycle.
- A push and a pop in the same cycle leave `count` unchanged. The queue never overflows because of the issue rule.

## Timing
- Reset values:
  - Outputs: `valid = 0`, `exception = 0`, `instruction = 0`, `pc = 0`.
  - State: `fetch_pc = resp_pc = RESET_PC`, `O = D = count = 0`, FSM in FETCH.
- `mem_req` is 0 while `rst = 1`. It rises in the first cycle after reset deasserts, with `mem_addr = RESET_PC`.
- Reset mid-operation discards everything. Responses to requests issued before reset are ignored by the environment; the bench must not return them.
- Latency: a response in cycle N is at the queue head with `valid = 1` in cycle N+1.
- Throughput: with a 1-cycle memory, `DEPTH = 2` and `id_ready` held at 1, the block sustains 1 instruction per cycle.
- The first valid output after a redirect in cycle R appears no earlier than R+3: request at R+1, response at R+2, valid at R+3.
- Holding `id_ready = 0` keeps `valid`, `instruction` and `pc` stable. Requests stop once `O + count = DEPTH`.

## Test plan
- Sequential fetch:
  - Setup: reset with `RESET_PC = 0`, 1-cycle memory returning `addr + 32'h100`, `id_ready = 1`.
  - Required: `pc` = 0, 4, 8, 12 on consecutive cycles, each `instruction = pc + 32'h100`, `valid` continuously high from cycle 3 after reset.
- Backpressure:
  - Stimulus: `id_ready = 0` for 5 cycles.
  - Required: `mem_req` drops after 2 outstanding plus queued entries. `pc` is held at 0. After release, 0, 4, 8 are delivered with no gaps or duplicates.
- Redirect with in-flight requests:
  - Setup: memory with 3-cycle latency, 2 requests outstanding.
  - Stimulus: `redirect = 1`, `redirect_pc = 32'h80`.
  - Required: both stale responses are dropped, and the next valid output has `pc = 32'h80`.
- Redirect coinciding with a response and a pop:
  - Required: the queue is empty next cycle, and `mem_addr = 32'h200` (the redirect target) on the following `mem_req`.
- Misaligned redirect:
  - Stimulus: `redirect_pc = 32'h102`.
  - Required: `valid = 1`, `exception = 1`, `pc = 32'h102`, `instruction = 32'h13`. After the pop, `valid = 0` and `mem_req = 0`. A redirect to `32'h40` resumes fetch at `32'h40`.
- Reset mid-stream:
  - Stimulus: assert `rst` with 2 queued entries.
  - Required: next cycle `valid = 0`, `O = 0`, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/riscv_if.sv
// riscv_if: instruction fetch stage feeding riscv_id.
// Issues word fetches, queues in-order responses, flushes on redirect.
module riscv_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        exception
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_TRAP  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   trap_pc_q, trap_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;

    logic [31:0] word_q [0:DEPTH-1];
    logic [31:0] qpc_q  [0:DEPTH-1];

    logic is_fetch;
    logic is_trap;
    logic head_ok;
    logic pop;
    logic accept;
    logic push;
    logic [CW:0] level;
    logic [CW:0] limit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign is_fetch = (state_q == S_FETCH);
    assign is_trap  = (state_q == S_TRAP);
    assign head_ok  = is_fetch && (count_q != '0);

    assign valid     = head_ok || is_trap;
    assign exception = is_trap;
    assign pop       = valid && id_ready;

    assign level = {1'b0, out_q} + {1'b0, count_q};
    assign limit = DEPTH_W + (CW + 1)'(pop);

    assign mem_req  = is_fetch && !rst && !redirect && (level < limit);
    assign mem_addr = fetch_pc_q;
    assign accept   = mem_req && mem_ready;
    assign push     = mem_rvalid && (disc_q == '0) && is_fetch && !redirect;

    // Output mux: trap marker, queue head, or zero when idle.
    always_comb begin
        instruction = '0;
        pc          = '0;
        if (is_trap) begin
            instruction = NOP;
            pc          = trap_pc_q;
        end else if (head_ok) begin
            instruction = word_q[head_q];
            pc          = qpc_q[head_q];
        end
    end

    // Next-state logic; a redirect overrides pop, response and accept.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        trap_pc_d  = trap_pc_q;
        out_d      = out_q + CW'(accept) - CW'(mem_rvalid);
        disc_d     = disc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            disc_d     = out_q - CW'(mem_rvalid);
            if (redirect_pc[1:0] == 2'b00) begin
                state_d = S_FETCH;
            end else begin
                state_d   = S_TRAP;
                trap_pc_d = redirect_pc;
            end
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (mem_rvalid && (disc_q != '0)) begin
                disc_d = disc_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                tail_d    = ptr_inc(tail_q);
            end
            if (pop && is_fetch) begin
                head_d = ptr_inc(head_q);
            end
            count_d = count_q + CW'(push) - CW'(pop && is_fetch);
            if (pop && is_trap) begin
                state_d = S_HALT;
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            trap_pc_q  <= '0;
            out_q      <= '0;
            disc_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            trap_pc_q  <= trap_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage; contents are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[tail_q] <= mem_rdata;
            qpc_q[tail_q]  <= resp_pc_q;
        end
    end

endmodule
